// File: rtl/shift_ctrl_pkg.sv
// +-----------------------------------------------------------------+
// | shift_ctrl_pkg : shared state encoding and count width          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package shift_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/button_cond.sv
// +-----------------------------------------------------------------+
// | button_cond : 2-flop synchronizer, optional debounce filter     |
// | (DEBOUNCE_EN).  Rev 1.0                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module button_cond
  import shift_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic cond
);

  // Flops reset to 1 so a released (high) button is assumed out of reset.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] stable_cnt;
  logic            filt_q;

  // Output follows the input only once it has differed for DB_CYCLES clocks in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      stable_cnt <= '0;
    end else if (sync_q[1] == filt_q) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_LAST) begin
      filt_q     <= sync_q[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign cond = filt_q;
`else
  // DB_CYCLES has no effect when the filter is not built.
  if (DB_CYCLES < 1) begin : g_db_unused
  end

  assign cond = sync_q[1];
`endif

endmodule

`default_nettype wire

// File: rtl/shift_control_unit.sv
// +-----------------------------------------------------------------+
// | shift_control_unit : button-driven control for an A/B shift     |
// | datapath; debounce enabled by DEBOUNCE_EN.  Rev 1.0             |
// +-----------------------------------------------------------------+
`default_nettype none

module shift_control_unit
  import shift_ctrl_pkg::*;
#(
  parameter int N_SHIFT   = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic             LoadA,
  input  logic             LoadB,
  output logic             Shift_En,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Bit_Cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SHIFT - 1);

  logic exec_s;
  logic loada_s;
  logic loadb_s;

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_exec_cond (
    .clk   (Clk),
    .rst_n (Reset),
    .raw   (Execute),
    .cond  (exec_s)
  );

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_loada_cond (
    .clk   (Clk),
    .rst_n (Reset),
    .raw   (LoadA),
    .cond  (loada_s)
  );

  button_cond #(.DB_CYCLES(DB_CYCLES)) u_loadb_cond (
    .clk   (Clk),
    .rst_n (Reset),
    .raw   (LoadB),
    .cond  (loadb_s)
  );

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_q;
  logic             done_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    done_nxt  = 1'b0;
    Shift_En  = 1'b0;
    Ld_A      = 1'b0;
    Ld_B      = 1'b0;
    case (state)
      IDLE: begin
        // A press wins over any pending load request on the same cycle.
        if (!exec_s) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end else begin
          Ld_A = ~loada_s;
          Ld_B = ~loadb_s;
        end
      end
      SHIFT: begin
        Shift_En = 1'b1;
        cnt_nxt  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
        end
      end
      HOLD: begin
        // Waiting for release is what makes a held button run only once.
        if (exec_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign Busy    = (state != IDLE);
  assign Done    = done_q;
  assign Bit_Cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/shift_control_unit.md
SHIFT_CONTROL_UNIT -- requirements
Module: shift_control_unit

Interface
REQ-001 The block SHALL have parameter N_SHIFT, default 8, meaning the number of Shift_En cycles per Execute press (legal range 1..15).
REQ-002 The block SHALL have parameter DB_CYCLES, default 16, meaning the debounce stability window in clocks (used only under DEBOUNCE_EN).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Execute, input, 1 bit: raw active-low button; low means pressed.
REQ-006 The block SHALL have port LoadA, input, 1 bit: raw active-low button requesting a Din load into register A.
REQ-007 The block SHALL have port LoadB, input, 1 bit: raw active-low button requesting a Din load into register B.
REQ-008 The block SHALL have port Shift_En, output, 1 bit: high means the A/B datapath shifts and computes one bit this cycle.
REQ-009 The block SHALL have port Ld_A, output, 1 bit: load enable for register A.
REQ-010 The block SHALL have port Ld_B, output, 1 bit: load enable for register B.
REQ-011 The block SHALL have port Busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse on the cycle after the last Shift_En.
REQ-013 The block SHALL have port Bit_Cnt, output, 4 bits: the count of shifts completed in the current operation.

Function
REQ-014 The block SHALL pass each button input through a 2-flop synchronizer; the synchronized (sync) value therefore lags the raw input by 2 clocks.
REQ-015 The state machine SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-016 IDLE -> SHIFT SHALL occur on the edge where sync Execute is low; Ld_A and Ld_B SHALL be 0 on that cycle (Execute has priority over loads).
REQ-017 In IDLE with sync Execute high, Ld_A SHALL equal the inverse of sync LoadA and Ld_B SHALL equal the inverse of sync LoadB (level-sensitive); both may be high together.
REQ-018 In SHIFT, Shift_En SHALL be 1 for exactly N_SHIFT consecutive cycles, Bit_Cnt SHALL increment by 1 per cycle starting from 0, and Ld_A/Ld_B SHALL be 0.
REQ-019 After the N_SHIFT-th shift, the FSM SHALL go to HOLD; Done SHALL be 1 for exactly that first HOLD cycle, and Bit_Cnt SHALL hold N_SHIFT.
REQ-020 HOLD -> IDLE SHALL occur on the edge where sync Execute is high, and Bit_Cnt SHALL clear to 0 on that transition.
REQ-021 Holding Execute low indefinitely SHALL produce exactly one operation; a new operation requires a release followed by another press.
REQ-022 LoadA/LoadB activity in SHIFT or HOLD SHALL be ignored and not queued.
REQ-023 Execute toggling during SHIFT SHALL NOT alter the count or the timing of Shift_En.

Reset
REQ-024 When Reset is low, the block SHALL asynchronously force state=IDLE, Shift_En=0, Ld_A=0, Ld_B=0, Busy=0, Done=0 and Bit_Cnt=0.
REQ-025 When Reset is low, the synchronizer and debounce flops SHALL reset to 1 (button released).
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation immediately with no Done pulse.
REQ-027 If Execute is held low across reset release, exactly one operation SHALL start after the synchronizer latency.

Configuration
REQ-028 With DEBOUNCE_EN defined, each sync button SHALL pass a filter that changes its output only after the input has been stable for DB_CYCLES consecutive clocks, adding DB_CYCLES of latency.
REQ-029 Without DEBOUNCE_EN, the filter SHALL be absent, the latency SHALL be exactly 2 clocks, and parameter DB_CYCLES SHALL be unused.

Structure
REQ-030 The state enum (IDLE, SHIFT, HOLD) and the Bit_Cnt width constant SHALL be defined in package shift_ctrl_pkg.
REQ-031 The synchronizer and the optional debounce filter SHALL be one sub-module, button_cond, instantiated three times.

Verification
REQ-032 The bench SHALL use N_SHIFT=8 with DEBOUNCE_EN undefined.
REQ-033 Pulse Execute low for 1 cycle -> Shift_En high 8 consecutive cycles, Done pulses once, Bit_Cnt=8, then return to IDLE with Bit_Cnt=0.
REQ-034 Hold Execute low for 40 cycles -> exactly 8 Shift_En cycles; Busy stays 1 until 2 clocks after release.
REQ-035 Drive LoadA low with LoadB high in IDLE for 3 cycles -> Ld_A high 3 cycles after 2-cycle lag, Ld_B=0; repeat during SHIFT -> Ld_A stays 0.
REQ-036 Drive Execute and LoadB low on the same edge -> SHIFT entered, Ld_B never asserted.
REQ-037 Assert Reset low at Bit_Cnt=4 -> all outputs 0 asynchronously; after release with Execute high, block stays IDLE.
REQ-038 With DEBOUNCE_EN defined and DB_CYCLES=16, toggle Execute every 3 cycles for 30 cycles -> no Shift_En; a steady press -> SHIFT entered 18 cycles after the press.
